// File: rtl/shift_add_mul_8.sv
// 8-bit ripple adder used as the shared partial-product accumulator.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module adder_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// Sequential 8x8 unsigned shift-add multiplier reusing one adder_8 per cycle.
// Latency: start accepted at E0, 8 iterations, done/product valid after E8 (9-cycle throughput).
// Backpressure: start is ignored while busy; accepted only in IDLE or DONE.
module shift_add_mul_8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic        hi_nz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        accept;
    logic        last_iter;

    logic [7:0]  m_q;
    logic [7:0]  hi_q;
    logic [7:0]  lo_q;
    logic [2:0]  cnt_q;

    logic [7:0]  add_b;
    logic [7:0]  add_sum;
    logic        add_cout;
    logic [15:0] shifted;

    // Add the multiplicand when the current multiplier LSB is set, then shift right.
    assign add_b   = lo_q[0] ? m_q : 8'h00;
    assign shifted = {add_cout, add_sum, lo_q[7:1]};

    adder_8 u_adder (
        .a    (hi_q),
        .b    (add_b),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign last_iter = (cnt_q == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q     <= 8'h00;
            hi_q    <= 8'h00;
            lo_q    <= 8'h00;
            cnt_q   <= 3'd0;
            product <= 16'h0000;
            hi_nz   <= 1'b0;
        end else if (accept) begin
            m_q   <= a;
            hi_q  <= 8'h00;
            lo_q  <= b;
            cnt_q <= 3'd0;
        end else if (state_q == RUN) begin
            hi_q  <= shifted[15:8];
            lo_q  <= shifted[7:0];
            cnt_q <= cnt_q + 3'd1;
            // Result registers only move on the final iteration so they hold steady otherwise.
            if (last_iter) begin
                product <= shifted;
                hi_nz   <= |shifted[15:8];
            end
        end
    end

endmodule

// File: tb/tb_shift_add_mul_8.sv
// Directed + randomized bench for shift_add_mul_8 against an arithmetic a*b reference.
module tb_shift_add_mul_8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        hi_nz;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    shift_add_mul_8 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .hi_nz   (hi_nz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned multiply.
    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        return 16'(x) * 16'(y);
    endfunction

    // Runs one operation from a negedge, returns at the negedge after the done cycle.
    task automatic do_op(input string tag, input logic [7:0] xa, input logic [7:0] xb);
        int          nbusy;
        logic [15:0] e;
        e     = ref_mul(xa, xb);
        start = 1'b1;
        a     = xa;
        b     = xb;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        nbusy = 0;
        repeat (8) begin
            if (busy && !done) nbusy++;
            @(negedge clk);
        end
        chk({tag, ".busy_cycles"}, 32'(nbusy), 32'd8);
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, ".product"}, 32'(product), 32'(e));
        chk({tag, ".hi_nz"}, 32'(hi_nz), 32'(e > 16'd255));
        @(negedge clk);
        chk({tag, ".done_single"}, 32'(done), 32'd0);
    endtask

    initial begin
        int          nd;
        int          ndone;
        int          bad;
        int          t_done[2];
        logic [15:0] p_done[2];
        logic [7:0]  ra;
        logic [7:0]  rb;

        rst_n = 1'b0;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.product", 32'(product), 32'd0);
        chk("reset.hi_nz", 32'(hi_nz), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("0d_x_0b", 8'h0D, 8'h0B);
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("hold.product", 32'(product), 32'h008F);
        chk("hold.no_done", 32'(ndone), 32'd0);

        do_op("ff_x_ff", 8'hFF, 8'hFF);
        do_op("00_x_a5", 8'h00, 8'hA5);
        do_op("80_x_02", 8'h80, 8'h02);

        // start re-pulsed mid-run with other operands must be ignored.
        start = 1'b1;
        a     = 8'h03;
        b     = 8'h05;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        a     = 8'h77;
        b     = 8'h77;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        repeat (14) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("ignore.done_count", 32'(ndone), 32'd1);
        chk("ignore.product", 32'(product), 32'h000F);

        // start held high: back-to-back acceptance in the DONE cycle.
        start = 1'b1;
        a     = 8'h10;
        b     = 8'h10;
        @(posedge clk);
        @(negedge clk);
        a   = 8'h02;
        b   = 8'h03;
        nd  = 0;
        bad = 0;
        for (int i = 0; i < 30 && nd < 2; i++) begin
            @(negedge clk);
            if (done) begin
                t_done[nd] = cyc;
                p_done[nd] = product;
                nd++;
                if (busy) bad++;
                if (nd == 2) start = 1'b0;
            end else if (!busy) begin
                bad++;
            end
        end
        chk("b2b.done_count", 32'(nd), 32'd2);
        if (nd == 2) begin
            chk("b2b.spacing", 32'(t_done[1] - t_done[0]), 32'd9);
            chk("b2b.product0", 32'(p_done[0]), 32'(ref_mul(8'h10, 8'h10)));
            chk("b2b.product1", 32'(p_done[1]), 32'(ref_mul(8'h02, 8'h03)));
        end
        chk("b2b.busy_profile", 32'(bad), 32'd0);
        @(negedge clk);
        chk("b2b.idle_after", 32'(busy | done), 32'd0);

        // Async reset in the 4th RUN cycle, between edges.
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.done", 32'(done), 32'd0);
        chk("arst.product", 32'(product), 32'd0);
        chk("arst.hi_nz", 32'(hi_nz), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("arst.no_resume", 32'(ndone), 32'd0);
        do_op("02_x_02", 8'h02, 8'h02);

        for (int i = 0; i < 10; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            do_op($sformatf("rand%0d", i), ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
